// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions.
// Holds the tag field layout, the memory request type code, the line geometry
// and the responder FSM state type used by the bus memory responder and its store.
package sysbus_pkg;

    localparam int         TAG_WRITE_BIT  = 12;
    localparam int         TAG_TYPE_LSB   = 8;
    localparam int         TAG_TYPE_WIDTH = 4;
    localparam logic [3:0] TAG_TYPE_MEM   = 4'h1;

    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_IDX_WIDTH = $clog2(BEATS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } bus_state_e;

endpackage

// File: rtl/bus_mem_array.sv
// Backing store for the bus memory responder.
// One asynchronous read port (single word) and one synchronous full-line write
// port. The store has no reset, so its contents survive a responder reset.
//   clk         : clock, write happens on the rising edge
//   rd_addr     : word index for the read port
//   rd_data     : word at rd_addr
//   wr_en       : commit wr_data as one full line
//   wr_line_idx : line number being written
//   wr_data     : the line's words, element k lands at word k of the line
module bus_mem_array
    import sysbus_pkg::*;
#(
    parameter int  WIDTH = 64,
    parameter int  WORDS = 4096,
    localparam int AW    = $clog2(WORDS),
    localparam int LW    = AW - BEAT_IDX_WIDTH
) (
    input  logic                                       clk,
    input  logic [AW-1:0]                              rd_addr,
    output logic [WIDTH-1:0]                           rd_data,
    input  logic                                       wr_en,
    input  logic [LW-1:0]                              wr_line_idx,
    input  logic [BEATS_PER_LINE-1:0][WIDTH-1:0]       wr_data
);

    logic [WIDTH-1:0] mem [WORDS];

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BEATS_PER_LINE; k++) begin
                mem[{wr_line_idx, BEAT_IDX_WIDTH'(k)}] <= wr_data[k];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus memory responder: serves line-sized memory reads and writes from a
// single initiator, one transaction outstanding at a time.
//   clk, reset                   : clock and asynchronous active-high reset
//   bus_reqcyc / bus_reqack      : request beat valid / accepted
//   bus_req, bus_reqtag          : address (first beat) or write data, tag
//   bus_respcyc / bus_respack    : response beat valid / consumed
//   bus_resp, bus_resptag        : read data beat, echoed read tag
//
// state | meaning
// IDLE  | waiting for a request header beat
// WDATA | collecting the 8 write data beats into the line buffer
// RWAIT | read latency countdown
// RESP  | returning 8 read beats, critical word first
module bus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = AW - BEAT_IDX_WIDTH;
    localparam logic [15:0] LAT_LOAD = 16'(READ_LATENCY - 1);
    localparam logic [BEAT_IDX_WIDTH-1:0] LAST_BEAT = BEAT_IDX_WIDTH'(BEATS_PER_LINE - 1);

    bus_state_e                                    state;
    logic [LW-1:0]                                 line_q;
    logic [BEAT_IDX_WIDTH-1:0]                     off_q;
    logic [BEAT_IDX_WIDTH-1:0]                     beat_q;
    logic [BUS_TAG_WIDTH-1:0]                      tag_q;
    logic [15:0]                                   lat_q;
    logic [BEATS_PER_LINE-1:0][BUS_DATA_WIDTH-1:0] wbuf_q;

    logic                                          xfer;
    logic                                          req_mem;
    logic                                          req_write;
    logic [AW-1:0]                                 req_idx;
    logic                                          wr_en;
    logic [BEATS_PER_LINE-1:0][BUS_DATA_WIDTH-1:0] wr_line;
    logic [BEAT_IDX_WIDTH-1:0]                     rd_beat;
    logic [AW-1:0]                                 rd_addr;
    logic [BUS_DATA_WIDTH-1:0]                     rd_data;

    assign bus_reqack = bus_reqcyc && (state == IDLE || state == WDATA);
    assign xfer       = bus_reqcyc && bus_reqack;

    // Byte address -> 64-bit word index; upper address bits alias modulo the store.
    assign req_idx   = bus_req[3 +: AW];
    assign req_mem   = (bus_reqtag[TAG_TYPE_LSB +: TAG_TYPE_WIDTH] == TAG_TYPE_MEM);
    assign req_write = bus_reqtag[TAG_WRITE_BIT];

    // The last data beat goes straight into the committed line, so the store
    // is updated on the same edge that accepts it.
    assign wr_en = (state == WDATA) && xfer && (beat_q == LAST_BEAT);

    always_comb begin
        wr_line            = wbuf_q;
        wr_line[LAST_BEAT] = bus_req;
    end

    // While a beat is being presented, the read port already points at the
    // next one so it can be loaded on the acknowledging edge. The 3-bit add
    // wraps the offset within the line.
    assign rd_beat = beat_q + BEAT_IDX_WIDTH'(bus_respcyc);
    assign rd_addr = {line_q, off_q + rd_beat};

    bus_mem_array #(
        .WIDTH (BUS_DATA_WIDTH),
        .WORDS (MEM_WORDS)
    ) u_array (
        .clk         (clk),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_line_idx (line_q),
        .wr_data     (wr_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            line_q      <= '0;
            off_q       <= '0;
            beat_q      <= '0;
            tag_q       <= '0;
            lat_q       <= '0;
            wbuf_q      <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_q <= '0;
                    if (xfer && req_mem) begin
                        line_q <= req_idx[AW-1:BEAT_IDX_WIDTH];
                        off_q  <= req_idx[BEAT_IDX_WIDTH-1:0];
                        tag_q  <= bus_reqtag;
                        if (req_write) begin
                            state <= WDATA;
                        end else begin
                            state <= RWAIT;
                            lat_q <= LAT_LOAD;
                        end
                    end
                end
                WDATA: begin
                    if (xfer) begin
                        wbuf_q[beat_q] <= bus_req;
                        if (beat_q == LAST_BEAT) begin
                            state  <= IDLE;
                            beat_q <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                RWAIT: begin
                    if (lat_q == '0) begin
                        state <= RESP;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RESP: begin
                    if (!bus_respcyc) begin
                        // First RESP cycle loads beat 0 from the store.
                        bus_respcyc <= 1'b1;
                        bus_resp    <= rd_data;
                        bus_resptag <= tag_q;
                    end else if (bus_respack) begin
                        if (beat_q == LAST_BEAT) begin
                            bus_respcyc <= 1'b0;
                            beat_q      <= '0;
                            state       <= IDLE;
                        end else begin
                            beat_q   <= beat_q + 1'b1;
                            bus_resp <= rd_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder with a word-array reference model and
// an expected-beat queue checked on every falling edge.
module tb_bus_mem_responder;

    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int MW  = 4096;
    localparam int RL  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;

    int nchecks = 0;
    int nerrors = 0;

    logic [63:0] model_mem [MW];
    logic [63:0] exp_data [$];
    logic [12:0] exp_tag [$];
    logic [63:0] got [8];
    logic [63:0] expv [8];
    logic [63:0] wdata [8];

    bus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .READ_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Response scoreboard: every presented beat must match the queue head.
    always @(negedge clk) begin
        if (!reset && bus_respcyc) begin
            if (exp_data.size() == 0) begin
                chk("resp_unexpected", 64'(bus_respcyc), 64'd0);
            end else begin
                chk("resp_data", bus_resp, exp_data[0]);
                chk("resp_tag", 64'(bus_resptag), 64'(exp_tag[0]));
                if (bus_respack) begin
                    void'(exp_data.pop_front());
                    void'(exp_tag.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t);
        int n;
        n = 0;
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        @(negedge clk);
        while (!bus_reqack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ack", 64'(bus_reqack), 64'd1);
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
    endtask

    // Sends the header and 'count' data beats from wdata; the model only
    // changes when the whole line went through.
    task automatic do_write(input logic [63:0] addr, input int count);
        int idx, base;
        idx  = int'((addr >> 3) % MW);
        base = idx - (idx % 8);
        send_beat(addr, 13'h1100);
        for (int k = 0; k < count; k++) send_beat(wdata[k], 13'h1100);
        if (count == 8) begin
            for (int k = 0; k < 8; k++) model_mem[base + k] = wdata[k];
        end
    endtask

    task automatic expect_line(input logic [63:0] addr, input logic [12:0] tag);
        int idx, base, off;
        idx  = int'((addr >> 3) % MW);
        base = idx - (idx % 8);
        off  = idx % 8;
        for (int k = 0; k < 8; k++) begin
            expv[k] = model_mem[base + ((off + k) % 8)];
            exp_data.push_back(expv[k]);
            exp_tag.push_back(tag);
        end
    endtask

    task automatic wait_respcyc(output int n);
        n = 0;
        while (!bus_respcyc && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                           input int hold_beat, input int hold_cycles);
        int n;
        expect_line(addr, tag);
        send_beat(addr, tag);
        wait_respcyc(n);
        chk("read_latency", 64'(n), 64'(RL + 1));
        for (int b = 0; b < 8; b++) begin
            wait_respcyc(n);
            chk("beat_valid", 64'(bus_respcyc), 64'd1);
            got[b] = bus_resp;
            if (b == hold_beat) begin
                for (int h = 0; h < hold_cycles; h++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", 64'(bus_respcyc), 64'd1);
                    chk("hold_data", bus_resp, expv[b]);
                    chk("hold_tag", 64'(bus_resptag), 64'(tag));
                end
            end
            bus_respack = 1'b1;
            @(posedge clk);
            #1;
            bus_respack = 1'b0;
        end
        chk("resp_done", 64'(bus_respcyc), 64'd0);
        chk("queue_drained", 64'(exp_data.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        exp_data.delete();
        exp_tag.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] lit_a [8];
        logic [63:0] lit_b [8];
        lit_a = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
        lit_b = '{64'h66, 64'h77, 64'h88, 64'h11, 64'h22, 64'h33, 64'h44, 64'h55};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
        chk("reset_resp", bus_resp, 64'd0);
        chk("reset_resptag", 64'(bus_resptag), 64'd0);
        chk("reset_reqack_idle", 64'(bus_reqack), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back line at 0x1000
        for (int k = 0; k < 8; k++) wdata[k] = 64'(8'h11 * (k + 1));
        do_write(64'h1000, 8);
        do_read(64'h1000, 13'h0100, -1, 0);
        for (int k = 0; k < 8; k++) chk("lit_read_1000", got[k], lit_a[k]);

        // Critical word first from offset 5
        do_read(64'h1028, 13'h0100, -1, 0);
        for (int k = 0; k < 8; k++) chk("lit_read_1028", got[k], lit_b[k]);

        // Backpressure on beat 3
        do_read(64'h1000, 13'h0100, 3, 10);
        chk("lit_hold_beat3", got[3], 64'h44);

        // Different line, other tag, offset 7
        for (int k = 0; k < 8; k++) wdata[k] = 64'hC0DE_0000_0000_0000 | 64'(k * 7 + 3);
        do_write(64'h1040, 8);
        do_read(64'h107F, 13'h0155, -1, 0);
        chk("lit_read_107f_first", got[0], 64'hC0DE_0000_0000_0034);
        chk("lit_read_107f_second", got[1], 64'hC0DE_0000_0000_0003);

        // Partial write aborted by reset keeps old contents
        for (int k = 0; k < 8; k++) wdata[k] = 64'hA0 + 64'(k);
        do_write(64'h2000, 8);
        for (int k = 0; k < 8; k++) wdata[k] = 64'hDEAD_0000 + 64'(k);
        do_write(64'h2000, 4);
        pulse_reset();
        do_read(64'h2000, 13'h0100, -1, 0);
        chk("lit_read_2000_first", got[0], 64'hA0);
        chk("lit_read_2000_last", got[7], 64'hA7);

        // Address aliasing modulo store size
        do_read(64'h1000 + 64'(MW * 8), 13'h0100, -1, 0);
        for (int k = 0; k < 8; k++) chk("lit_alias", got[k], lit_a[k]);

        // Non-memory tags: single-beat no-op, no response
        send_beat(64'h1000, 13'h0200);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("noop_no_resp", 64'(bus_respcyc), 64'd0);
        end
        send_beat(64'h1000, 13'h1200);
        do_read(64'h1010, 13'h0100, -1, 0);
        chk("lit_after_noop", got[0], 64'h33);

        // Asynchronous reset in the middle of a response
        expect_line(64'h1000, 13'h0100);
        send_beat(64'h1000, 13'h0100);
        wait_respcyc(n);
        chk("pre_reset_valid", 64'(bus_respcyc), 64'd1);
        pulse_reset();
        repeat (3) begin
            chk("post_reset_idle", 64'(bus_respcyc), 64'd0);
            @(posedge clk);
            #1;
        end
        do_read(64'h1008, 13'h0100, -1, 0);
        chk("lit_after_reset", got[0], 64'h22);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
